// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Single-port RAM arbiter between fetch (IF) and load/store (LS).
//            Optional macro ARB_ROUND_ROBIN_EN: round-robin tie breaking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be in 1..4");
        end
    endgenerate

    localparam logic [2:0] c_LAT_CNT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_owner_ls;
    logic              r_we;
    logic              r_if_gnt;
    logic              r_ls_gnt;
    logic              r_if_rvalid;
    logic              r_ls_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_any_req;
    logic w_pick_ls;

    assign w_any_req = if_req | ls_req;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last_ls = 1 when LS held the most recent grant; the other side wins a tie.
    logic r_last_ls;
    assign w_pick_ls = ls_req & (~if_req | ~r_last_ls);
`else
    assign w_pick_ls = ls_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_owner_ls  <= 1'b0;
            r_we        <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_ls   <= 1'b0;
`endif
        end else begin
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    // RESP samples requests exactly like IDLE so streams run gap-free.
                    if (w_any_req) begin
                        r_state    <= S_ACCESS;
                        r_owner_ls <= w_pick_ls;
                        r_we       <= w_pick_ls & ls_we;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_pick_ls & ls_we;
                        r_mem_addr <= w_pick_ls ? ls_addr : if_addr;
                        r_if_gnt   <= ~w_pick_ls;
                        r_ls_gnt   <= w_pick_ls;
                        if (w_pick_ls) begin
                            r_mem_wdata <= ls_wdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_ls  <= w_pick_ls;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_cnt   <= c_LAT_CNT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_RESP;
                        if (r_owner_ls) begin
                            r_ls_rdata  <= r_we ? '0 : mem_rdata;
                            r_ls_rvalid <= 1'b1;
                        end else begin
                            r_if_rdata  <= mem_rdata;
                            r_if_rvalid <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign ls_gnt    = r_ls_gnt;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter with a latency-accurate RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // RAM model: read data appears LAT cycles after mem_en; filler 0xDEAD elsewhere.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] rd_pipe [0:LAT-1];
    assign mem_rdata = rd_pipe[LAT-1];

    function automatic logic [DW-1:0] preload(input int a);
        case (a)
            5:       return 16'hBEEF;
            16:      return 16'h1111;
            255:     return 16'hA5A5;
            default: return {8'(a), ~8'(a)};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(i);
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= 16'hDEAD;
        end else begin
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                mem_en, mem_we, mem_addr, mem_wdata, busy};
    endfunction

    // Called at posedge+1 of an IDLE cycle T; returns at T+LAT+3, back in IDLE.
    task automatic run_txn(input bit ls, input bit we, input logic [7:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp);
        ls_req   = ls;
        if_req   = !ls;
        ls_we    = we;
        ls_addr  = ls ? addr : ~addr;
        if_addr  = ls ? ~addr : addr;
        ls_wdata = wd;
        tick;
        chk("txn_gnt", {if_gnt, ls_gnt}, ls ? 2'b01 : 2'b10);
        chk("txn_mem_en", mem_en, 1'b1);
        chk("txn_mem_we", mem_we, we);
        chk("txn_mem_addr", mem_addr, addr);
        if (we) chk("txn_mem_wdata", mem_wdata, wd);
        chk("txn_busy_access", busy, 1'b1);
        tick;
        if_req = 1'b0;
        ls_req = 1'b0;
        for (int c = 2; c < LAT + 2; c++) begin
            chk("txn_wait_quiet", {mem_en, if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy}, 6'b000001);
            tick;
        end
        chk("txn_rvalid", {if_rvalid, ls_rvalid}, ls ? 2'b01 : 2'b10);
        chk("txn_rdata", ls ? ls_rdata : if_rdata, exp);
        chk("txn_busy_resp", busy, 1'b1);
        tick;
        chk("txn_idle", {if_rvalid, ls_rvalid, busy}, 3'b000);
    endtask

    // Holds the selected requests until n grants are seen; checks order and spacing.
    task automatic run_stream(input bit want_if, input bit want_ls, input int n,
                              input logic [7:0] exp_order);
        logic [7:0] order;
        int g, last, bad_int, both, bad_en;
        order = '0; g = 0; last = 0; bad_int = 0; both = 0; bad_en = 0;
        if_req  = want_if;
        ls_req  = want_ls;
        ls_we   = 1'b0;
        if_addr = 8'h05;
        ls_addr = 8'hFF;
        for (int cyc = 1; cyc <= n * (LAT + 2) + 6 && g < n; cyc++) begin
            tick;
            if (if_gnt && ls_gnt) both++;
            if (if_rvalid && ls_rvalid) both++;
            if (mem_en !== (if_gnt | ls_gnt)) bad_en++;
            if (if_gnt || ls_gnt) begin
                order[g] = ls_gnt;
                if (g > 0 && cyc - last != LAT + 2) bad_int++;
                last = cyc;
                g++;
                if (g == n) begin
                    if_req = 1'b0;
                    ls_req = 1'b0;
                end
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        chk("stream_grant_count", g, n);
        chk("stream_grant_order", order, exp_order);
        chk("stream_interval_errs", bad_int, 0);
        chk("stream_dual_assert", both, 0);
        chk("stream_mem_en_outside_access", bad_en, 0);
        repeat (LAT + 2) tick;
        chk("stream_drain_idle", busy, 1'b0);
    endtask

    typedef struct {
        bit          ls;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int c_lg, c_ig, c_lrv, c_irv, n_ifg, n_lsrv, bad;

        vecs[0] = '{0, 0, 8'h05, 16'h0000, 16'hBEEF};
        vecs[1] = '{1, 1, 8'h20, 16'h1234, 16'h0000};
        vecs[2] = '{1, 0, 8'h20, 16'h0000, 16'h1234};
        vecs[3] = '{0, 0, 8'h20, 16'h0000, 16'h1234};
        vecs[4] = '{1, 0, 8'hFF, 16'h5555, 16'hA5A5};
        vecs[5] = '{1, 1, 8'h00, 16'hFFFF, 16'h0000};
        vecs[6] = '{0, 0, 8'h00, 16'h0000, 16'hFFFF};

        rst = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
        repeat (3) tick;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("post_reset_idle", all_outs(), 64'd0);

        // Asynchronous reset in the middle of WAIT drops the read.
        if_req = 1'b1;
        if_addr = 8'h10;
        tick;
        tick;
        if_req = 1'b0;
        chk("pre_reset_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 2 * LAT + 4; c++) begin
            tick;
            if (if_rvalid || ls_rvalid || busy) bad++;
        end
        chk("no_rvalid_after_reset", bad, 0);
        run_txn(0, 0, 8'h10, 16'h0, 16'h1111);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].ls, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp);
        chk("if_rdata_hold", if_rdata, 16'hFFFF);
        chk("ls_rdata_store_zero", ls_rdata, 16'h0000);

        // Simultaneous requests: LS first, IF granted in the cycle after LS RESP.
        c_lg = -1; c_ig = -1; c_lrv = -1; c_irv = -1;
        if_req = 1'b1; if_addr = 8'h05;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'hFF;
        for (int cyc = 1; cyc <= 2 * LAT + 8; cyc++) begin
            tick;
            if (c_lg >= 0 && cyc == c_lg + 1) ls_req = 1'b0;
            if (c_ig >= 0 && cyc == c_ig + 1) if_req = 1'b0;
            if (ls_gnt && c_lg < 0) c_lg = cyc;
            if (if_gnt && c_ig < 0) c_ig = cyc;
            if (ls_rvalid && c_lrv < 0) c_lrv = cyc;
            if (if_rvalid && c_irv < 0) c_irv = cyc;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        chk("tie_ls_gnt_cycle", c_lg, 1);
        chk("tie_ls_rvalid_cycle", c_lrv, LAT + 2);
        chk("tie_if_gnt_cycle", c_ig, LAT + 3);
        chk("tie_if_rvalid_cycle", c_irv, 2 * LAT + 4);
        chk("tie_ls_rdata", ls_rdata, 16'hA5A5);
        chk("tie_if_rdata", if_rdata, 16'hBEEF);

`ifdef ARB_ROUND_ROBIN_EN
        run_stream(1, 1, 4, 8'h05);
`else
        run_stream(1, 1, 4, 8'h0F);
`endif
        run_stream(1, 0, 3, 8'h00);

        // IF request raised and withdrawn while LS is busy must never be granted.
        n_ifg = 0; n_lsrv = 0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h05;
        tick;
        if (if_gnt) n_ifg++;
        tick;
        ls_req = 1'b0;
        if_req = 1'b1;
        if_addr = 8'h10;
        tick;
        if_req = 1'b0;
        for (int c = 0; c < 2 * LAT + 6; c++) begin
            if (if_gnt) n_ifg++;
            if (ls_rvalid) n_lsrv++;
            tick;
        end
        chk("withdrawn_if_no_gnt", n_ifg, 0);
        chk("withdrawn_ls_one_rvalid", n_lsrv, 1);
        chk("withdrawn_ls_rdata", ls_rdata, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port instruction/data RAM between the CPU fetch unit (IF) and the load/store unit (LS). It sits between the core pipeline and the memory inside toplevel. One transaction is in flight at a time. The block sequences memory enable, address, write data and fixed read latency, and returns a registered response to the winning requester.

Parameters:
ADDR_W, 8, address width in words
DATA_W, 16, data word width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
if_req  input  1  fetch request; held until if_gnt
if_addr  input  ADDR_W  fetch address; stable while if_req=1
if_gnt  output  1  one-cycle grant pulse to fetch
if_rvalid  output  1  one-cycle pulse; if_rdata valid
if_rdata  output  DATA_W  fetched instruction word
ls_req  input  1  load/store request; held until ls_gnt
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  load/store address
ls_wdata  input  DATA_W  store data
ls_gnt  output  1  one-cycle grant pulse to LS
ls_rvalid  output  1  one-cycle pulse; load data valid or store acknowledged
ls_rdata  output  DATA_W  load data; 0 for store ack
mem_en  output  1  memory access strobe, one cycle per transaction
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst=0, asynchronous): FSM -> IDLE. All outputs are 0. Latency counter is 0. Owner register is IF. RR pointer is "last=IF". Any in-flight transaction is dropped, and no rvalid is issued afterwards.
- States:
  - IDLE: sample requests.
  - ACCESS: one cycle, mem_en=1.
  - WAIT: count MEM_LAT cycles.
  - RESP: one cycle, rvalid.
- IDLE, cycle T, with any req=1:
  - Select the winner and register owner.
  - Capture addr, we and wdata.
  - Go to ACCESS.
  - If no req, stay in IDLE.
- ACCESS, cycle T+1:
  - Drive winner's gnt=1, mem_en=1, mem_we = ls_we (0 for IF), plus mem_addr and mem_wdata from the captured values.
  - Load the counter with MEM_LAT. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0 (cycle T+1+MEM_LAT), register mem_rdata into the owner's rdata (0 for a store). Go to RESP.
- RESP, cycle T+MEM_LAT+2:
  - Pulse the owner's rvalid for one cycle.
  - Sample requests in this same cycle, exactly as IDLE does. If any req=1, go directly to ACCESS; otherwise go to IDLE.
- Latency and throughput: request sampled to rvalid is MEM_LAT+2 cycles. Back-to-back transactions complete every MEM_LAT+2 cycles.
- Output stability:
  - mem_addr and mem_wdata hold their values outside ACCESS. mem_en and mem_we are 0 outside ACCESS.
  - rdata outputs hold their last value until the next response to the same requester.
  - gnt and rvalid are never asserted for both requesters in the same cycle.
- Requester rules:
  - A requester must keep req high until gnt is seen, and drop it in the cycle after gnt unless it wants another transaction.
  - req=1 in a sampling cycle after its own gnt is a new transaction.
- Default priority: if both requests are present at the sampling point, LS wins, because loads and stores stall the pipeline.
- Request withdrawn before being sampled: ignored. No gnt is issued.
- busy is 1 in ACCESS, WAIT and RESP.
- Counter width: 3 bits. MEM_LAT outside 1..4 is a configuration error and fails elaboration.

Optional Feature:
ARB_ROUND_ROBIN_EN
- When defined: on a simultaneous request, grant the requester that was not granted last.
  - The pointer updates on every grant. After reset the pointer is "last=IF", so LS wins the first tie.
  - A requester that is alone is always granted.
- When undefined: fixed LS-over-IF priority. No pointer register exists.

Test Plan:
1. Reset mid-WAIT, MEM_LAT=3: IF read to 0x10, assert rst=0 during WAIT -> all outputs 0 immediately; no if_rvalid after rst=1; next request is serviced normally.
2. Single IF read, MEM_LAT=1: if_req with if_addr=0x05 and mem[0x05]=0xBEEF sampled at T -> if_gnt=1, mem_en=1, mem_addr=0x05 at T+1; if_rvalid=1, if_rdata=0xBEEF at T+3; busy high T+1..T+3.
3. Store then load, MEM_LAT=2: ls store of 0x1234 to 0x20 -> mem_we=1, mem_wdata=0x1234 in ACCESS, ls_rvalid with ls_rdata=0 at T+4. The following load from 0x20 -> ls_rdata=0x1234.
4. Simultaneous requests, macro off: if_req and ls_req both held high -> ls_gnt first, then if_gnt in RESP+1 of the LS transaction; if_rvalid 4 cycles after ls_rvalid with MEM_LAT=2.
5. Simultaneous requests, ARB_ROUND_ROBIN_EN defined: both requests held high continuously for 4 transactions -> grant order LS, IF, LS, IF; no cycle with both gnt or both rvalid.
6. Back-to-back IF, MEM_LAT=4: if_req held high -> if_gnt pulses every 6 cycles; mem_en never asserted during WAIT.
